// File: rtl/flyer_pkg.sv
// Shared types and constants for the flyer sprite array: slot states,
// spawn height table and default sprite ROM bases.
package flyer_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FLY  = 1'b1
  } slot_state_t;

  localparam int          PosY_OFF   = 480;
  localparam logic [17:0] SPR_BASE_A = 18'd171995;
  localparam logic [17:0] SPR_BASE_B = 18'd179355;
  localparam logic [5:0]  LFSR_SEED  = 6'b101010;

  localparam logic [10:0] HEIGHT_TBL [3] = '{11'd210, 11'd270, 11'd300};

  // Random value buckets: 16/64 low, 32/64 middle, 16/64 high.
  function automatic logic [10:0] spawn_height(input logic [5:0] lfsr);
    if (lfsr < 6'd16) begin
      return HEIGHT_TBL[0];
    end else if (lfsr < 6'd48) begin
      return HEIGHT_TBL[1];
    end else begin
      return HEIGHT_TBL[2];
    end
  endfunction

endpackage

// File: rtl/draw_flyer_array_lfsr.sv
// Fibonacci LFSR for x^6+x^5+1, stepping only when enabled.
module draw_flyer_array_lfsr #(
  parameter int               WIDTH = 6,
  parameter logic [WIDTH-1:0] SEED  = 6'b101010
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= SEED;
    end else if (i_en) begin
      r_q <= {r_q[WIDTH-2:0], r_q[WIDTH-1] ^ r_q[WIDTH-2]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/draw_flyer_array.sv
// Flyer sprite array: spawns, moves and animates up to four flyers and
// returns the registered sprite ROM address for the queried pixel.
module draw_flyer_array
  import flyer_pkg::*;
#(
  parameter int          N_FLYERS   = 2,
  parameter int          SPR_W      = 92,
  parameter int          SPR_H      = 80,
  parameter logic [17:0] BASE_A     = SPR_BASE_A,
  parameter logic [17:0] BASE_B     = SPR_BASE_B,
  parameter int          ANIM_TICKS = 10,
  parameter int          SPEED      = 4,
  parameter int          SPAWN_X    = 1000,
  parameter int          MIN_GAP    = 300
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         frame_tick,
  input  logic                         Dead,
  input  logic                         Speed_up,
  input  logic                         spawn_en,
  input  logic [9:0]                   WriteX,
  input  logic [9:0]                   WriteY,
  output logic                         flyer_on,
  output logic [17:0]                  address,
  output logic [1:0]                   hit_idx,
  output logic [N_FLYERS-1:0]          active_mask,
  output logic [N_FLYERS-1:0][10:0]    Flyer_PosX,
  output logic [N_FLYERS-1:0][10:0]    Flyer_PosY
);

  localparam int                 CNT_W     = $clog2(ANIM_TICKS + 1);
  localparam logic signed [10:0] SPAWN_X_S = 11'(SPAWN_X);
  localparam logic signed [10:0] GAP_LIM   = 11'(SPAWN_X - MIN_GAP);
  localparam logic signed [10:0] EXIT_X    = 11'(-SPR_W);
  localparam logic signed [10:0] STEP_N    = 11'(SPEED);
  localparam logic signed [10:0] STEP_F    = 11'(2 * SPEED);
  localparam logic signed [10:0] POSY_RST  = 11'(PosY_OFF);
  localparam logic signed [11:0] SPR_W_S   = 12'(SPR_W);
  localparam logic signed [11:0] SPR_H_S   = 12'(SPR_H);

  logic [5:0]          w_lfsr;
  logic [N_FLYERS-1:0] w_fly;
  logic [N_FLYERS-1:0] w_spawnSel;
  logic [N_FLYERS-1:0] w_hit;
  logic signed [10:0]  w_posX [N_FLYERS];
  logic [17:0]         w_off  [N_FLYERS];
  logic                w_blocked;
  logic                w_found;
  logic                w_spawnGo;
  logic [CNT_W-1:0]    r_wingCnt;
  logic                r_frameSel;
  logic [17:0]         w_base;
  logic [17:0]         w_addr;
  logic [1:0]          w_idx;
  logic                w_anyHit;

  draw_flyer_array_lfsr #(
    .WIDTH (6),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_en    (frame_tick),
    .o_q     (w_lfsr)
  );

  // Wing flap: one shared counter so every flyer flaps in step.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wingCnt  <= CNT_W'(1);
      r_frameSel <= 1'b0;
    end else if (frame_tick && !Dead) begin
      if (r_wingCnt == CNT_W'(ANIM_TICKS)) begin
        r_wingCnt  <= CNT_W'(1);
        r_frameSel <= ~r_frameSel;
      end else begin
        r_wingCnt <= r_wingCnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_blocked  = 1'b0;
    w_found    = 1'b0;
    w_spawnSel = '0;
    for (int i = 0; i < N_FLYERS; i++) begin
      if (w_fly[i] && (w_posX[i] > GAP_LIM)) begin
        w_blocked = 1'b1;
      end
      if (!w_found && !w_fly[i]) begin
        w_spawnSel[i] = 1'b1;
        w_found       = 1'b1;
      end
    end
    w_spawnGo = frame_tick & spawn_en & ~Dead & w_lfsr[0] & ~w_blocked;
  end

  for (genvar g = 0; g < N_FLYERS; g++) begin : g_slot
    slot_state_t        r_state;
    logic signed [10:0] r_posX;
    logic signed [10:0] r_posY;
    logic signed [10:0] w_nextX;
    logic signed [11:0] w_dx;
    logic signed [11:0] w_dy;

    assign w_nextX = r_posX - (Speed_up ? STEP_F : STEP_N);

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        r_state <= S_IDLE;
        r_posX  <= SPAWN_X_S;
        r_posY  <= POSY_RST;
      end else if (frame_tick) begin
        if (r_state == S_IDLE) begin
          if (w_spawnGo && w_spawnSel[g]) begin
            r_state <= S_FLY;
            r_posX  <= SPAWN_X_S;
            r_posY  <= spawn_height(w_lfsr);
          end
        end else if (!Dead) begin
          if (w_nextX <= EXIT_X) begin
            r_state <= S_IDLE;
            r_posX  <= SPAWN_X_S;
            r_posY  <= POSY_RST;
          end else begin
            r_posX <= w_nextX;
          end
        end
      end
    end

    // Offsets are signed so a sprite hanging off the left edge still draws.
    assign w_dx = $signed({2'b00, WriteX}) - $signed({r_posX[10], r_posX});
    assign w_dy = $signed({2'b00, WriteY}) - $signed({r_posY[10], r_posY});

    assign w_hit[g] = (r_state == S_FLY) &&
                      (w_dx >= 12'sd0) && (w_dx < SPR_W_S) &&
                      (w_dy >= 12'sd0) && (w_dy < SPR_H_S);
    assign w_off[g] = 18'($unsigned(w_dy)) * 18'(SPR_W) + 18'($unsigned(w_dx));

    assign w_fly[g]      = (r_state == S_FLY);
    assign w_posX[g]     = r_posX;
    assign Flyer_PosX[g] = r_posX;
    assign Flyer_PosY[g] = r_posY;
  end

  assign active_mask = w_fly;
  assign w_base      = r_frameSel ? BASE_B : BASE_A;

  // Walk from the top index down so the lowest hitting slot wins.
  always_comb begin
    w_anyHit = 1'b0;
    w_idx    = '0;
    w_addr   = '0;
    for (int i = N_FLYERS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_anyHit = 1'b1;
        w_idx    = 2'(i);
        w_addr   = w_base + w_off[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flyer_on <= 1'b0;
      address  <= '0;
      hit_idx  <= '0;
    end else begin
      flyer_on <= w_anyHit;
      address  <= w_addr;
      hit_idx  <= w_idx;
    end
  end

endmodule

// File: tb/tb_draw_flyer_array.sv
// Scoreboard bench for draw_flyer_array: a default instance and a zero-gap
// instance (so flyers can overlap) checked against a behavioural model.
module tb_draw_flyer_array;

  localparam int NF = 2;

  typedef struct {
    logic        on;
    logic [17:0] addr;
    logic [1:0]  idx;
  } exp_t;

  logic                   clk;
  logic                   resetN;
  logic                   frameTick;
  logic                   dead;
  logic                   speedUp;
  logic                   spawnEn;
  logic [9:0]             writeX;
  logic [9:0]             writeY;
  logic [1:0]             flyerOn;
  logic [1:0][17:0]       addrOut;
  logic [1:0][1:0]        hitIdx;
  logic [1:0][NF-1:0]     mask;
  logic [1:0][NF-1:0][10:0] posX;
  logic [1:0][NF-1:0][10:0] posY;

  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;
  exp_t scoreQ [2][$];

  bit       mFly [2][NF];
  int       mX   [2][NF];
  int       mY   [2][NF];
  bit [5:0] mLfsr;
  int       mCnt;
  bit       mSel;

  draw_flyer_array u_dut (
    .Clk         (clk),
    .Reset_n     (resetN),
    .frame_tick  (frameTick),
    .Dead        (dead),
    .Speed_up    (speedUp),
    .spawn_en    (spawnEn),
    .WriteX      (writeX),
    .WriteY      (writeY),
    .flyer_on    (flyerOn[0]),
    .address     (addrOut[0]),
    .hit_idx     (hitIdx[0]),
    .active_mask (mask[0]),
    .Flyer_PosX  (posX[0]),
    .Flyer_PosY  (posY[0])
  );

  draw_flyer_array #(.MIN_GAP(0)) u_dutGap (
    .Clk         (clk),
    .Reset_n     (resetN),
    .frame_tick  (frameTick),
    .Dead        (dead),
    .Speed_up    (speedUp),
    .spawn_en    (spawnEn),
    .WriteX      (writeX),
    .WriteY      (writeY),
    .flyer_on    (flyerOn[1]),
    .address     (addrOut[1]),
    .hit_idx     (hitIdx[1]),
    .active_mask (mask[1]),
    .Flyer_PosX  (posX[1]),
    .Flyer_PosY  (posY[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic void modelReset();
    mLfsr = 6'b101010;
    mCnt  = 1;
    mSel  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NF; i++) begin
        mFly[k][i] = 1'b0;
        mX[k][i]   = 1000;
        mY[k][i]   = 480;
      end
    end
  endfunction

  function automatic void modelTick();
    int gap;
    int sy;
    int nx;
    bit blocked;
    bit done;
    sy = (mLfsr < 16) ? 210 : ((mLfsr < 48) ? 270 : 300);
    for (int k = 0; k < 2; k++) begin
      gap     = (k == 0) ? 300 : 0;
      blocked = 1'b0;
      done    = 1'b0;
      for (int i = 0; i < NF; i++) begin
        if (mFly[k][i] && mX[k][i] > 1000 - gap) blocked = 1'b1;
      end
      for (int i = 0; i < NF; i++) begin
        if (!mFly[k][i]) begin
          if (spawnEn && !dead && mLfsr[0] && !blocked && !done) begin
            mFly[k][i] = 1'b1;
            mX[k][i]   = 1000;
            mY[k][i]   = sy;
            done       = 1'b1;
          end
        end else if (!dead) begin
          nx = mX[k][i] - (speedUp ? 8 : 4);
          if (nx <= -92) begin
            mFly[k][i] = 1'b0;
            mX[k][i]   = 1000;
            mY[k][i]   = 480;
          end else begin
            mX[k][i] = nx;
          end
        end
      end
    end
    if (!dead) begin
      if (mCnt == 10) begin
        mCnt = 1;
        mSel = !mSel;
      end else begin
        mCnt++;
      end
    end
    mLfsr = {mLfsr[4:0], mLfsr[5] ^ mLfsr[4]};
  endfunction

  function automatic exp_t predictPixel(int k, int wx, int wy);
    exp_t e;
    bit   found;
    e.on   = 1'b0;
    e.addr = '0;
    e.idx  = '0;
    found  = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (!found && mFly[k][i] &&
          wx >= mX[k][i] && wx < mX[k][i] + 92 &&
          wy >= mY[k][i] && wy < mY[k][i] + 80) begin
        found  = 1'b1;
        e.on   = 1'b1;
        e.idx  = 2'(i);
        e.addr = 18'((mSel ? 179355 : 171995) + (wy - mY[k][i]) * 92 + (wx - mX[k][i]));
      end
    end
    return e;
  endfunction

  // Aim most queries inside a live sprite so hits, addresses and priority get exercised.
  task automatic nextQuery(output int wx, output int wy);
    int k;
    int s;
    int lo;
    int hi;
    phase++;
    k = (phase / 2) % 2;
    s = phase % 2;
    if ((phase % 5) == 4 || !mFly[k][s]) begin
      wx = int'($urandom_range(1023, 0));
      wy = int'($urandom_range(479, 0));
    end else begin
      lo = (mX[k][s] < 0) ? -mX[k][s] : 0;
      hi = (mX[k][s] + 91 > 1023) ? 1023 - mX[k][s] : 91;
      wx = mX[k][s] + int'($urandom_range(hi, lo));
      wy = mY[k][s] + int'($urandom_range(79, 0));
    end
  endtask

  task automatic applyStimulus(input bit ft, input int wx, input int wy);
    exp_t e;
    @(negedge clk);
    frameTick = ft;
    writeX    = 10'(wx);
    writeY    = 10'(wy);
    for (int k = 0; k < 2; k++) scoreQ[k].push_back(predictPixel(k, wx, wy));
    @(posedge clk);
    #1;
    frameTick = 1'b0;
    if (ft) modelTick();
    for (int k = 0; k < 2; k++) begin
      if (scoreQ[k].size() == 0) begin
        checkOutput($sformatf("scoreEmpty%0d", k), 32'(1), 32'(0));
      end else begin
        e = scoreQ[k].pop_front();
        checkOutput($sformatf("pixOn%0d", k), 32'(flyerOn[k]), 32'(e.on));
        checkOutput($sformatf("pixAddr%0d", k), 32'(addrOut[k]), 32'(e.addr));
        checkOutput($sformatf("pixIdx%0d", k), 32'(hitIdx[k]), 32'(e.idx));
      end
      if (ft) begin
        checkOutput($sformatf("mask%0d", k), 32'(mask[k]), 32'({mFly[k][1], mFly[k][0]}));
        for (int i = 0; i < NF; i++) begin
          checkOutput($sformatf("posX%0d_%0d", k, i), 32'($signed(posX[k][i])), 32'(mX[k][i]));
          checkOutput($sformatf("posY%0d_%0d", k, i), 32'($signed(posY[k][i])), 32'(mY[k][i]));
        end
      end
    end
  endtask

  task automatic runTick();
    int wx;
    int wy;
    nextQuery(wx, wy);
    applyStimulus(1'b1, wx, wy);
    nextQuery(wx, wy);
    applyStimulus(1'b0, wx, wy);
  endtask

  initial begin
    int n;
    resetN    = 1'b0;
    frameTick = 1'b0;
    dead      = 1'b0;
    speedUp   = 1'b0;
    spawnEn   = 1'b0;
    writeX    = '0;
    writeY    = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("resetOn", 32'(flyerOn[k]), 32'(0));
      checkOutput("resetAddr", 32'(addrOut[k]), 32'(0));
      checkOutput("resetIdx", 32'(hitIdx[k]), 32'(0));
      checkOutput("resetMask", 32'(mask[k]), 32'(0));
      checkOutput("resetPosX", 32'($signed(posX[k][0])), 32'(1000));
      checkOutput("resetPosY", 32'($signed(posY[k][1])), 32'(480));
    end

    @(negedge clk);
    resetN  = 1'b1;
    spawnEn = 1'b1;

    runTick();
    checkOutput("tick1NoSpawn", 32'(mask[0]), 32'(0));
    runTick();
    checkOutput("spawnMask", 32'(mask[0]), 32'(1));
    checkOutput("spawnX", 32'($signed(posX[0][0])), 32'(1000));
    checkOutput("spawnY", 32'($signed(posY[0][0])), 32'(270));

    runTick();
    checkOutput("gapTwoFly", 32'(mask[1]), 32'(3));
    applyStimulus(1'b0, 1000, 290);
    checkOutput("overlapOn", 32'(flyerOn[1]), 32'(1));
    checkOutput("overlapIdx", 32'(hitIdx[1]), 32'(0));

    speedUp = 1'b1;
    repeat (5) runTick();
    speedUp = 1'b0;
    checkOutput("speedDrop", 32'($signed(posX[0][0])), 32'(956));

    dead = 1'b1;
    repeat (20) runTick();
    dead = 1'b0;
    checkOutput("deadHold", 32'($signed(posX[0][0])), 32'(956));
    runTick();
    checkOutput("resumeStep", 32'($signed(posX[0][0])), 32'(952));

    n = 0;
    while (mX[0][0] != 100 && n < 400) begin
      runTick();
      if (mX[0][0] == 800) checkOutput("gapBlock800", 32'(mask[0]), 32'(1));
      n++;
    end
    checkOutput("reach100", 32'(mX[0][0]), 32'(100));
    applyStimulus(1'b0, 150, 300);
    checkOutput("queryOn", 32'(flyerOn[0]), 32'(1));
    checkOutput("queryAddr", 32'(addrOut[0]), 32'((mSel ? 179355 : 171995) + 30 * 92 + 50));

    n = 0;
    while (mX[0][0] != -88 && n < 100) begin
      runTick();
      n++;
    end
    checkOutput("reachM88", 32'($signed(posX[0][0])), 32'(-88));
    runTick();
    checkOutput("exitMaskBit0", 32'(mask[0][0]), 32'(0));
    checkOutput("exitPosX", 32'($signed(posX[0][0])), 32'(1000));
    checkOutput("exitPosY", 32'($signed(posY[0][0])), 32'(480));

    n = 0;
    while (!(mFly[0][0] && mFly[0][1]) && n < 400) begin
      runTick();
      n++;
    end
    checkOutput("twoActive", 32'(mask[0]), 32'(3));
    applyStimulus(1'b0, mX[0][0] + 10, mY[0][0] + 5);
    checkOutput("preResetOn", 32'(flyerOn[0]), 32'(1));

    #2;
    resetN = 1'b0;
    #1;
    checkOutput("asyncOn", 32'(flyerOn[0]), 32'(0));
    checkOutput("asyncAddr", 32'(addrOut[0]), 32'(0));
    checkOutput("asyncIdx", 32'(hitIdx[0]), 32'(0));
    checkOutput("asyncMask0", 32'(mask[0]), 32'(0));
    checkOutput("asyncMask1", 32'(mask[1]), 32'(0));
    checkOutput("asyncPosX", 32'($signed(posX[0][1])), 32'(1000));
    modelReset();
    for (int k = 0; k < 2; k++) scoreQ[k].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;

    runTick();
    checkOutput("postResetNoSpawn", 32'(mask[0]), 32'(0));
    runTick();
    checkOutput("postResetSpawn", 32'(mask[0]), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_flyer_array.md
DRAW_FLYER_ARRAY -- requirements
Module: draw_flyer_array

Interface
REQ-001 Parameter N_FLYERS, 2, number of independent flyer slots (1..4).
REQ-002 Parameter SPR_W, 92, sprite width in pixels.
REQ-003 Parameter SPR_H, 80, sprite height in pixels.
REQ-004 Parameter BASE_A, 18'd171995, ROM base address of wing-down frame.
REQ-005 Parameter BASE_B, 18'd179355, ROM base address of wing-up frame.
REQ-006 Parameter ANIM_TICKS, 10, frame_ticks per wing toggle.
REQ-007 Parameter SPEED, 4, pixels moved per frame_tick at normal speed.
REQ-008 Parameter SPAWN_X, 1000, X position loaded at spawn.
REQ-009 Parameter MIN_GAP, 300, minimum X spacing between the newest flyer and a new spawn.
REQ-010 Port Clk  in  1  the single clock; frame_tick is a one-cycle enable in this domain.
REQ-011 Port Reset_n  in  1  asynchronous, active-low reset.
REQ-012 Port frame_tick  in  1  one-Clk-cycle pulse per video frame.
REQ-013 Port Dead  in  1  freezes motion and animation while high.
REQ-014 Port Speed_up  in  1  doubles motion step while high.
REQ-015 Port spawn_en  in  1  spawning permitted (cactus clear-zone gate from the top level).
REQ-016 Port WriteX, WriteY  in  10 each  pixel coordinate being queried.
REQ-017 Port flyer_on  out  1  registered: queried pixel lies inside an active flyer.
REQ-018 Port address  out  18  registered: sprite ROM address for the queried pixel.
REQ-019 Port hit_idx  out  2  registered: index of the slot that produced flyer_on.
REQ-020 Port active_mask  out  N_FLYERS  slot i is in FLY.
REQ-021 Port Flyer_PosX, Flyer_PosY  out  N_FLYERS x 11 signed  per-slot position, for collision logic.

Function
REQ-022 Each slot SHALL run the FSM IDLE -> FLY -> IDLE; all state changes occur only on cycles with frame_tick=1.
REQ-023 An internal 6-bit LFSR (x^6+x^5+1, seed 6'b101010) SHALL advance once per frame_tick, also while Dead.
REQ-024 Spawn: on a frame_tick with spawn_en=1, Dead=0, lfsr[0]=1, and no FLY slot with PosX > SPAWN_X-MIN_GAP, the lowest-index IDLE slot SHALL enter FLY with PosX=SPAWN_X; at most one spawn per tick.
REQ-025 Spawn height from the same tick's lfsr value: 0..15 -> PosY=210; 16..47 -> PosY=270; 48..63 -> PosY=300.
REQ-026 In FLY with Dead=0, PosX SHALL decrease by SPEED, or 2*SPEED when Speed_up=1, per frame_tick, in 11-bit signed arithmetic.
REQ-027 When the next PosX would be <= -SPR_W, the slot SHALL instead return to IDLE with PosX=SPAWN_X and PosY=480.
REQ-028 A shared wing counter SHALL count 1..ANIM_TICKS per frame_tick while Dead=0 and toggle the frame select on wrap; the first frame after reset is BASE_A.
REQ-029 Pixel hit for slot i: slot i in FLY, PosX<=WriteX<PosX+SPR_W, and PosY<=WriteY<PosY+SPR_H, with signed compares so partially off-screen-left sprites still draw.
REQ-030 Overlapping hits SHALL resolve to the lowest index.
REQ-031 address = base + (WriteY-PosY)*SPR_W + (WriteX-PosX) for the winning slot; latency SHALL be exactly 1 Clk from WriteX/WriteY to flyer_on/address/hit_idx.
REQ-032 With no hit, flyer_on=0 and address and hit_idx SHALL be 0.
REQ-033 The pixel lookup SHALL use the position registers' pre-update value on a frame_tick cycle.
REQ-034 Dead deasserting SHALL resume motion from the frozen positions with no jump.

Reset
REQ-035 Reset_n=0 SHALL asynchronously force: all slots IDLE, PosX=SPAWN_X, PosY=480, LFSR=seed, wing counter=1, frame select=BASE_A, and flyer_on, address, hit_idx, active_mask all 0.
REQ-036 Reset asserted mid-flight SHALL discard all flyers; the first spawn after release requires a new qualifying frame_tick.

Structure
REQ-037 Package flyer_pkg SHALL hold the slot-state enum, the three-entry height table, PosY_OFF=480, and the sprite base constants.
REQ-038 The existing LFSR module SHALL be instantiated as the single sub-module (width 6); the per-slot logic is a generate loop.

Verification
REQ-039 Reset release, spawn_en=1, LFSR seed 101010 -> first qualifying tick spawns slot 0 at X=1000 with the height from the REQ-025 table; active_mask=01.
REQ-040 Slot 0 in flight, Speed_up=1 for 5 ticks -> PosX drops by 40; Dead=1 for 20 ticks -> PosX and wing frame unchanged.
REQ-041 Slot 0 at PosX=-88, tick -> slot 0 returns IDLE, PosX=1000, PosY=480, active_mask bit 0 clears.
REQ-042 Slot 0 at X=100, Y=270, query (WriteX=150, WriteY=300) -> one cycle later flyer_on=1, address=BASE+30*92+50.
REQ-043 Two slots overlapping the queried pixel -> hit_idx=0; slot 0 at PosX=800 blocks a spawn until PosX<=700.
REQ-044 Reset_n pulsed low mid-flight with two slots active -> all outputs 0 immediately, without waiting for a Clk edge.
